// File: rtl/uart_cmd_pkg.sv
// Shared encodings and constants for the UART KEY=DECIMAL command parser.
package uart_cmd_pkg;

    localparam int MAX_KEY_CHARS_DEF = 4;
    localparam int MAX_DIGITS_DEF    = 10;

    // Longest accepted command: full key, '=', full digit field.
    function automatic int cmd_len(input int key_chars, input int digits);
        return key_chars + 1 + digits;
    endfunction

    localparam int MAX_CMD_LEN_DEF = cmd_len(MAX_KEY_CHARS_DEF, MAX_DIGITS_DEF);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_KEY    = 4'b0010,
        S_VALUE  = 4'b0100,
        S_FINISH = 4'b1000
    } state_t;

    localparam logic [1:0] ERR_FMT = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_OVF = 2'd3;

    localparam logic [7:0] ASC_EQ = 8'h3D;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_Z  = 8'h5A;

endpackage

// File: rtl/uart_cmd_dec_acc.sv
// Registered decimal accumulator: acc = acc*10 + digit, with a sticky overflow flag.
module uart_cmd_dec_acc (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        clr,
    input  logic        dig_en,
    input  logic [3:0]  digit,
    output logic [31:0] acc,
    output logic        ovf,
    output logic        ovf_nxt
);

    logic [35:0] acc_x;
    logic [35:0] acc_nxt;

    assign acc_x   = {4'b0, acc};
    assign acc_nxt = (acc_x << 3) + (acc_x << 1) + {32'b0, digit};
    // Flagged in the same cycle as the digit so the parser can reject it immediately.
    assign ovf_nxt = dig_en && (acc_nxt[35:32] != 4'b0);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (dig_en) begin
            if (ovf_nxt) ovf <= 1'b1;
            else         acc <= acc_nxt[31:0];
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses one "KEY=DECIMAL" payload from the UART string receiver, one byte per clock.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_KEY_CHARS = MAX_KEY_CHARS_DEF,
    parameter int MAX_DIGITS    = MAX_DIGITS_DEF
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [1095:0]              rx_string,
    input  logic [7:0]                 rx_length,
    input  logic                       rx_done,
    output logic [8*MAX_KEY_CHARS-1:0] cmd_key,
    output logic [31:0]                cmd_value,
    output logic                       cmd_vld,
    output logic                       cmd_err,
    output logic [1:0]                 cmd_err_code,
    output logic                       busy,
    output logic                       cmd_drop
);

    localparam int MAX_CMD_LEN = cmd_len(MAX_KEY_CHARS, MAX_DIGITS);
    localparam int KW          = 8 * MAX_KEY_CHARS;
    localparam int IDXW        = $clog2(MAX_CMD_LEN + 1);
    localparam int KCW         = $clog2(MAX_KEY_CHARS + 1);
    localparam int DCW         = $clog2(MAX_DIGITS + 1);

    localparam logic [7:0]      LEN_LIM = 8'(MAX_CMD_LEN);
    localparam logic [IDXW-1:0] IDX_LIM = IDXW'(MAX_CMD_LEN);
    localparam logic [KCW-1:0]  KEY_LIM = KCW'(MAX_KEY_CHARS);
    localparam logic [DCW-1:0]  DIG_LIM = DCW'(MAX_DIGITS);

    state_t                           state;
    logic [MAX_CMD_LEN-1:0][7:0]      str_sh;
    logic [7:0]                       len_sh;
    logic [IDXW-1:0]                  idx;
    logic [KW-1:0]                    key;
    logic [KCW-1:0]                   key_cnt;
    logic [DCW-1:0]                   dig_cnt;

    logic [7:0]  cur;
    logic        at_end, is_last, is_alpha, is_digit;
    logic        acc_clr, dig_en;
    logic [31:0] acc;
    logic        acc_ovf, acc_ovf_nxt;
    logic        err_hit;
    logic [1:0]  err_c;
    logic        unused_rx;

    assign unused_rx = ^rx_string[1095:8*MAX_CMD_LEN];

    assign cur      = (idx < IDX_LIM) ? str_sh[idx] : 8'h00;
    assign at_end   = (len_sh == 8'(idx));
    assign is_last  = (len_sh == 8'(idx) + 8'd1);
    assign is_alpha = (cur >= ASC_A) && (cur <= ASC_Z);
    assign is_digit = (cur >= ASC_0) && (cur <= ASC_9);
    assign busy     = (state != S_IDLE);

    assign acc_clr = (state == S_IDLE) && rx_done;
    assign dig_en  = (state == S_VALUE) && !at_end && is_digit && (dig_cnt < DIG_LIM);

    uart_cmd_dec_acc u_acc (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (acc_clr),
        .dig_en  (dig_en),
        .digit   (cur[3:0]),
        .acc     (acc),
        .ovf     (acc_ovf),
        .ovf_nxt (acc_ovf_nxt)
    );

    // Rejection decision for the byte under examination; length checks win at idx 0.
    always_comb begin
        err_hit = 1'b0;
        err_c   = ERR_FMT;
        case (state)
            S_KEY: begin
                if (idx == '0 && len_sh == 8'd0) begin
                    err_hit = 1'b1;
                end else if (idx == '0 && len_sh > LEN_LIM) begin
                    err_hit = 1'b1;
                    err_c   = ERR_LEN;
                end else if (at_end) begin
                    err_hit = 1'b1;
                end else if (!(is_alpha && key_cnt < KEY_LIM) &&
                             !(cur == ASC_EQ && key_cnt != '0)) begin
                    err_hit = 1'b1;
                end
            end
            S_VALUE: begin
                if (at_end) begin
                    err_hit = (dig_cnt == '0);
                end else if (!dig_en) begin
                    err_hit = 1'b1;
                end else if (acc_ovf_nxt || acc_ovf) begin
                    err_hit = 1'b1;
                    err_c   = ERR_OVF;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        cmd_vld      <= 1'b0;
        cmd_err      <= 1'b0;
        cmd_err_code <= 2'd0;
        cmd_drop     <= 1'b0;
        if (sys_rst) begin
            state     <= S_IDLE;
            str_sh    <= '0;
            len_sh    <= '0;
            idx       <= '0;
            key       <= '0;
            key_cnt   <= '0;
            dig_cnt   <= '0;
            cmd_key   <= '0;
            cmd_value <= '0;
        end else begin
            if (rx_done && state != S_IDLE) cmd_drop <= 1'b1;
            if (err_hit) begin
                cmd_err      <= 1'b1;
                cmd_err_code <= err_c;
                state        <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (rx_done) begin
                        str_sh  <= rx_string[8*MAX_CMD_LEN-1:0];
                        len_sh  <= rx_length;
                        idx     <= '0;
                        key     <= '0;
                        key_cnt <= '0;
                        dig_cnt <= '0;
                        state   <= S_KEY;
                    end
                    S_KEY: begin
                        idx <= idx + IDXW'(1);
                        if (is_alpha) begin
                            key     <= {key[KW-9:0], cur};
                            key_cnt <= key_cnt + KCW'(1);
                        end else begin
                            state <= S_VALUE;
                        end
                    end
                    S_VALUE: begin
                        // A digit as the final byte completes the command this cycle.
                        if (at_end) begin
                            state <= S_FINISH;
                        end else begin
                            idx     <= idx + IDXW'(1);
                            dig_cnt <= dig_cnt + DCW'(1);
                            if (is_last) state <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        cmd_key   <= key;
                        cmd_value <= acc;
                        cmd_vld   <= 1'b1;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected pulses queued at stimulus, checked at output.
module tb_uart_cmd_parser;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [1095:0] rx_string = '0;
    logic [7:0]    rx_length = '0;
    logic          rx_done = 1'b0;
    logic [31:0]   cmd_key;
    logic [31:0]   cmd_value;
    logic          cmd_vld, cmd_err, busy, cmd_drop;
    logic [1:0]    cmd_err_code;

    uart_cmd_parser dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .rx_string    (rx_string),
        .rx_length    (rx_length),
        .rx_done      (rx_done),
        .cmd_key      (cmd_key),
        .cmd_value    (cmd_value),
        .cmd_vld      (cmd_vld),
        .cmd_err      (cmd_err),
        .cmd_err_code (cmd_err_code),
        .busy         (busy),
        .cmd_drop     (cmd_drop)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          err;
        logic [1:0]  code;
        logic [31:0] key;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] last_key = '0;
    logic [31:0] last_val = '0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (cmd_vld === 1'b1 || cmd_err === 1'b1) begin
            exp_t e;
            tests++;
            if (cmd_vld && cmd_err) begin
                fails++;
                $display("FAIL vld_err_overlap: cycle %0d both high, required exclusive", cyc);
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: cycle %0d vld=%0b err=%0b code=%0d, required none",
                         cyc, cmd_vld, cmd_err, cmd_err_code);
            end else begin
                e = sb.pop_front();
                if (cmd_err !== e.err || cyc != e.cyc ||
                    (e.err && cmd_err_code !== e.code) ||
                    (!e.err && (cmd_key !== e.key || cmd_value !== e.val)) ||
                    (e.err && (cmd_key !== last_key || cmd_value !== last_val))) begin
                    fails++;
                    $display("FAIL result: got err=%0b code=%0d key=%h val=%0d cyc=%0d, required err=%0b code=%0d key=%h val=%0d cyc=%0d",
                             cmd_err, cmd_err_code, cmd_key, cmd_value, cyc,
                             e.err, e.code, e.err ? last_key : e.key, e.err ? last_val : e.val, e.cyc);
                end
                if (!e.err) begin
                    last_key = e.key;
                    last_val = e.val;
                end
            end
        end
    end

    function automatic logic [1095:0] pack(input string s);
        logic [1095:0] v = '0;
        for (int i = 0; i < s.len(); i++) v[8*i +: 8] = s[i];
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Pulses rx_done this cycle; optionally queues the expected outcome dly cycles later.
    task automatic fire(input string s, input int len, input bit chk, input bit err,
                        input logic [1:0] code, input logic [31:0] key, input logic [31:0] val,
                        input int dly);
        exp_t e;
        if (chk) begin
            e.err = err; e.code = code; e.key = key; e.val = val; e.cyc = cyc + dly;
            sb.push_back(e);
        end
        rx_string = pack(s);
        rx_length = len[7:0];
        rx_done   = 1'b1;
        step(1);
        rx_done   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step(1);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d results pending, required 0", name, sb.size());
            sb.delete();
        end
        step(2);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step(3);
        tests++;
        if ({cmd_key, cmd_value, cmd_vld, cmd_err, cmd_err_code, busy, cmd_drop} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: key=%h val=%h vld=%b err=%b code=%b busy=%b drop=%b, required all 0",
                     cmd_key, cmd_value, cmd_vld, cmd_err, cmd_err_code, busy, cmd_drop);
        end
        sys_rst = 1'b0;
        step(2);
    endtask

    task automatic test_freq();
        fire("FREQ=12345", 10, 1, 0, 2'd0, 32'h4652_4551, 32'd12345, 12);
        for (int k = 1; k <= 12; k++) begin
            tests++;
            if (busy !== (k <= 11)) begin
                fails++;
                $display("FAIL freq_busy: T+%0d busy=%b, required %b", k, busy, (k <= 11));
            end
            step(1);
        end
        wait_drain("freq");
    endtask

    task automatic test_overflow();
        fire("A=4294967295", 12, 1, 0, 2'd0, 32'h0000_0041, 32'hFFFF_FFFF, 14);
        wait_drain("max_value");
        fire("A=4294967296", 12, 1, 1, 2'd3, '0, '0, 13);
        wait_drain("overflow");
        tests++;
        if (cmd_value !== 32'hFFFF_FFFF || cmd_key !== 32'h41) begin
            fails++;
            $display("FAIL ovf_hold: key=%h val=%h, required 00000041 ffffffff", cmd_key, cmd_value);
        end
    endtask

    task automatic test_format();
        string s[4] = '{"FREQ12", "=5", "AB=", "ab=1"};
        int    d[4] = '{6, 2, 5, 2};
        for (int i = 0; i < 4; i++) begin
            fire(s[i], s[i].len(), 1, 1, 2'd1, '0, '0, d[i]);
            wait_drain("format");
        end
    endtask

    task automatic test_length();
        fire("ABCDEFGHIJKLMNOP", 16, 1, 1, 2'd2, '0, '0, 2);
        wait_drain("len16");
        fire("", 0, 1, 1, 2'd1, '0, '0, 2);
        wait_drain("len0");
        fire("ABCD=4000000000", 15, 1, 0, 2'd0, 32'h4142_4344, 32'd4000000000, 17);
        wait_drain("len15");
    endtask

    task automatic test_back_to_back();
        fire("G=7", 3, 1, 0, 2'd0, 32'h47, 32'd7, 5);
        step(1);
        rx_string = pack("Z=1");
        rx_length = 8'd3;
        rx_done   = 1'b1;
        step(1);
        rx_done   = 1'b0;
        tests++;
        if (cmd_drop !== 1'b1) begin
            fails++;
            $display("FAIL drop_pulse: cmd_drop=%b at T+3, required 1", cmd_drop);
        end
        step(1);
        tests++;
        if (cmd_drop !== 1'b0) begin
            fails++;
            $display("FAIL drop_width: cmd_drop=%b at T+4, required 0", cmd_drop);
        end
        step(1);
        fire("X=42", 4, 1, 0, 2'd0, 32'h58, 32'd42, 6);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        fire("FREQ=12345", 10, 0, 0, 2'd0, '0, '0, 0);
        step(3);
        sys_rst = 1'b1;
        step(1);
        sys_rst  = 1'b0;
        last_key = '0;
        last_val = '0;
        tests++;
        if ({cmd_key, cmd_value, cmd_vld, cmd_err, cmd_err_code, busy, cmd_drop} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: key=%h val=%h vld=%b err=%b busy=%b, required all 0",
                     cmd_key, cmd_value, cmd_vld, cmd_err, busy);
        end
        step(15);
        fire("B=9", 3, 1, 0, 2'd0, 32'h42, 32'd9, 5);
        wait_drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_freq();
        test_overflow();
        test_format();
        test_length();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
